// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the multi-cycle divider; stalls EX, then writes HI/LO.
// Optional DIV_ZERO_EXC_EN traps a zero divisor in IDLE instead of starting the divider.
module div_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            ex_div_op_i,
  input  logic [DATA_W-1:0]     ex_op1_i,
  input  logic [DATA_W-1:0]     ex_op2_i,
  input  logic                  flush_i,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_ready_i,
  output logic                  div_start_o,
  output logic                  div_annul_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_op1_o,
  output logic [DATA_W-1:0]     div_op2_o,
  output logic                  stallreq_o,
  output logic                  hilo_we_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  div_timeout_o,
  output logic                  div_zero_exc_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] op1_q, op2_q, hi_q, lo_q;
  logic sgn_q, op_valid, zero_div, go, busy, wd, run;
  assign op_valid = ex_div_op_i == 2'b01 || ex_div_op_i == 2'b10;
`ifdef DIV_ZERO_EXC_EN
  assign zero_div = state == IDLE && op_valid && !flush_i && ex_op2_i == '0;
`else
  assign zero_div = 1'b0;
`endif
  assign go   = state == IDLE && op_valid && !flush_i && !zero_div;
  assign busy = state == BUSY;
  assign wd   = busy && !flush_i && !div_ready_i && cnt == CW'(TIMEOUT - 1);
  assign run  = busy && !flush_i && !wd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op1_q <= '0;
      op2_q <= '0;
      sgn_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= go ? '0 : busy ? cnt + 1'b1 : cnt;
      if (go) begin
        op1_q <= ex_op1_i;
        op2_q <= ex_op2_i;
        sgn_q <= ex_div_op_i == 2'b01;
      end
      // flush wins over a result arriving in the same cycle
      if (busy && div_ready_i && !flush_i) {hi_q, lo_q} <= div_result_i;
    end
  always_comb begin
    state_nx = state == IDLE ? (go ? BUSY : IDLE) :
               state == BUSY ? (flush_i || wd ? IDLE : div_ready_i ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    div_start_o    = go || run;
    stallreq_o     = go || run;
    div_annul_o    = busy && (flush_i || wd);
    div_timeout_o  = wd;
    div_signed_o   = go ? ex_div_op_i == 2'b01 : busy && sgn_q;
    div_op1_o      = go ? ex_op1_i : busy ? op1_q : '0;
    div_op2_o      = go ? ex_op2_i : busy ? op2_q : '0;
    hilo_we_o      = state == DONE && !flush_i;
    hi_o           = hi_q;
    lo_o           = lo_q;
    div_zero_exc_o = zero_div;
  end
endmodule
